// File: rtl/updown_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : updown_seq_pkg
//  Description : Shared command-opcode and FSM state encodings for the
//                up/down count sequencer and its step unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package updown_seq_pkg;

    // Command opcodes carried on cmd_op
    localparam logic [1:0] OP_UP    = 2'b00;
    localparam logic [1:0] OP_DOWN  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_SWEEP = 2'b11;

    // Sequencer FSM states
    localparam int         STATE_W  = 2;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_SWEEP  = 2'd2;

endpackage : updown_seq_pkg
`default_nettype wire

// File: rtl/updown_step_unit.sv
`default_nettype none
// ============================================================================
//  Module      : updown_step_unit
//  Description : Counter datapath. Holds the counter value and computes the
//                next position for a wrapping step or a bouncing (triangle)
//                step, reporting whether a wrapping step crosses the end of
//                range and whether a bouncing step reverses direction.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_step_unit
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             bounce_i,
    output logic [WIDTH-1:0] value_o,
    output logic             wrap_o,
    output logic             flip_o
);

    localparam logic [WIDTH-1:0] C_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] C_ZERO = '0;
    localparam logic [WIDTH-1:0] C_ONE  = WIDTH'(1);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;

    // Next position: bouncing steps reflect off the ends, wrapping steps roll over
    always_comb begin
        value_d = dir_i ? (value_q + C_ONE) : (value_q - C_ONE);
        wrap_o  = 1'b0;
        flip_o  = 1'b0;
        if (bounce_i) begin
            if (dir_i && (value_q == C_MAX)) begin
                value_d = C_MAX - C_ONE;
                flip_o  = 1'b1;
            end else if (!dir_i && (value_q == C_ZERO)) begin
                value_d = C_ONE;
                flip_o  = 1'b1;
            end
        end else begin
            wrap_o = dir_i ? (value_q == C_MAX) : (value_q == C_ZERO);
        end
    end

    // Counter register: load has priority over a step
    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= '0;
        end else if (load_i) begin
            value_q <= load_val_i;
        end else if (en_i) begin
            value_q <= value_d;
        end
    end

    assign value_o = value_q;

endmodule : updown_step_unit
`default_nettype wire

// File: rtl/updown_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : updown_count_sequencer
//  Description : Command-driven sequencer for the up/down counter. Accepts
//                UP/DOWN/LOAD/SWEEP commands over valid/ready, steps the
//                counter once per non-halted clock, and reports direction,
//                busy, done and wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module updown_count_sequencer
    import updown_seq_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [STEP_W-1:0] cmd_arg,
    input  logic [WIDTH-1:0]  cmd_data,
    input  logic              halt,
    output logic [WIDTH-1:0]  out,
    output logic              up,
    output logic              busy,
    output logic              done,
    output logic              wrap
);

    logic [STATE_W-1:0] state_q, state_d;
    logic [STEP_W-1:0]  rem_q,   rem_d;
    logic               up_q,    up_d;
    logic               done_q,  done_d;
    logic               wrap_q,  wrap_d;

    logic               w_accept;
    logic               w_load;
    logic               w_step_en;
    logic               w_bounce;
    logic               w_wrap;
    logic               w_flip;

    // State register plus the registered status flags; reset aborts any operation
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            up_q    <= 1'b1;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            up_q    <= up_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
        end
    end

    // Next-state: command decode in IDLE, step bookkeeping in RUN/SWEEP
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        up_d    = up_q;
        done_d  = 1'b0;
        wrap_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_accept) begin
                    if (cmd_op == OP_LOAD) begin
                        done_d = 1'b1;
                    end else if (cmd_arg == '0) begin
                        // Zero-length step commands complete immediately
                        done_d = 1'b1;
                    end else begin
                        rem_d = cmd_arg;
                        if (cmd_op == OP_SWEEP) begin
                            up_d    = 1'b1;
                            state_d = S_SWEEP;
                        end else begin
                            up_d    = (cmd_op == OP_UP);
                            state_d = S_RUN;
                        end
                    end
                end
            end
            S_RUN, S_SWEEP: begin
                if (w_step_en) begin
                    rem_d = rem_q - STEP_W'(1);
                    if (state_q == S_RUN) begin
                        wrap_d = w_wrap;
                    end else if (w_flip) begin
                        up_d = ~up_q;
                    end
                    // Final step lands the FSM in IDLE so the next command can follow
                    if (rem_q == STEP_W'(1)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs and handshake decode derived from the current state
    always_comb begin
        cmd_ready = (state_q == S_IDLE) && !reset;
        busy      = (state_q == S_RUN) || (state_q == S_SWEEP);
        w_accept  = cmd_valid && cmd_ready;
        w_load    = w_accept && (cmd_op == OP_LOAD);
        w_step_en = busy && !halt;
        w_bounce  = (state_q == S_SWEEP);
    end

    updown_step_unit #(
        .WIDTH (WIDTH)
    ) u_step (
        .clk        (clk),
        .rst        (reset),
        .en_i       (w_step_en),
        .dir_i      (up_q),
        .load_i     (w_load),
        .load_val_i (cmd_data),
        .bounce_i   (w_bounce),
        .value_o    (out),
        .wrap_o     (w_wrap),
        .flip_o     (w_flip)
    );

    assign up   = up_q;
    assign done = done_q;
    assign wrap = wrap_q;

endmodule : updown_count_sequencer
`default_nettype wire

// File: tb/tb_updown_count_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_updown_count_sequencer
//  Description : Directed self-checking bench for updown_count_sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_count_sequencer;

    localparam logic [1:0] C_UP    = 2'b00;
    localparam logic [1:0] C_DOWN  = 2'b01;
    localparam logic [1:0] C_LOAD  = 2'b10;
    localparam logic [1:0] C_SWEEP = 2'b11;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = 2'b00;
    logic [3:0] cmd_arg = 4'd0;
    logic [2:0] cmd_data = 3'd0;
    logic       halt = 1'b0;
    logic [2:0] out;
    logic       up;
    logic       busy;
    logic       done;
    logic       wrap;

    int n_cmp = 0;
    int n_err = 0;

    logic [2:0] exp_up10  [10] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd2};
    logic [2:0] exp_dn7   [7]  = '{3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7, 3'd6};
    logic [2:0] exp_sw12  [12] = '{3'd6, 3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3};
    logic       exp_swup  [12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

    updown_count_sequencer #(
        .WIDTH  (3),
        .STEP_W (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_arg   (cmd_arg),
        .cmd_data  (cmd_data),
        .halt      (halt),
        .out       (out),
        .up        (up),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Present a command for exactly one edge (caller ensures cmd_ready is high)
    task automatic send(input logic [1:0] op, input logic [3:0] arg, input logic [2:0] data);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
    endtask

    initial begin
        // ---- 1: reset ----
        reset = 1'b1;
        tick();
        chk("rst_ready_low", {7'd0, cmd_ready}, 8'd0);
        tick();
        chk("rst_ready_low2", {7'd0, cmd_ready}, 8'd0);
        reset = 1'b0;
        #1;
        chk("rst_out", {5'd0, out}, 8'd0);
        chk("rst_up", {7'd0, up}, 8'd1);
        chk("rst_busy", {7'd0, busy}, 8'd0);
        chk("rst_done", {7'd0, done}, 8'd0);
        chk("rst_wrap", {7'd0, wrap}, 8'd0);
        chk("rst_ready_high", {7'd0, cmd_ready}, 8'd1);

        // ---- 2: UP 10 from 0 ----
        send(C_UP, 4'd10, 3'd0);
        chk("up10_acc_busy", {7'd0, busy}, 8'd1);
        chk("up10_acc_out", {5'd0, out}, 8'd0);
        chk("up10_acc_ready", {7'd0, cmd_ready}, 8'd0);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("up10_out[%0d]", i), {5'd0, out}, {5'd0, exp_up10[i]});
            chk($sformatf("up10_wrap[%0d]", i), {7'd0, wrap}, (i == 7) ? 8'd1 : 8'd0);
            chk($sformatf("up10_done[%0d]", i), {7'd0, done}, (i == 9) ? 8'd1 : 8'd0);
            chk($sformatf("up10_busy[%0d]", i), {7'd0, busy}, (i < 9) ? 8'd1 : 8'd0);
        end
        chk("up10_ready_on_done", {7'd0, cmd_ready}, 8'd1);
        tick();
        chk("up10_done_clear", {7'd0, done}, 8'd0);

        // ---- 3: LOAD 5 then DOWN 7 (back to back on done) ----
        send(C_LOAD, 4'd0, 3'd5);
        chk("load5_out", {5'd0, out}, 8'd5);
        chk("load5_done", {7'd0, done}, 8'd1);
        chk("load5_busy", {7'd0, busy}, 8'd0);
        chk("load5_up", {7'd0, up}, 8'd1);
        send(C_DOWN, 4'd7, 3'd0);
        chk("dn7_up", {7'd0, up}, 8'd0);
        for (int i = 0; i < 7; i++) begin
            tick();
            chk($sformatf("dn7_out[%0d]", i), {5'd0, out}, {5'd0, exp_dn7[i]});
            chk($sformatf("dn7_wrap[%0d]", i), {7'd0, wrap}, (i == 5) ? 8'd1 : 8'd0);
            chk($sformatf("dn7_done[%0d]", i), {7'd0, done}, (i == 6) ? 8'd1 : 8'd0);
        end
        chk("dn7_up_end", {7'd0, up}, 8'd0);

        // ---- 4: LOAD 5 then SWEEP 12 ----
        send(C_LOAD, 4'd0, 3'd5);
        chk("load5b_out", {5'd0, out}, 8'd5);
        chk("load5b_wrap", {7'd0, wrap}, 8'd0);
        send(C_SWEEP, 4'd12, 3'd0);
        chk("sw_acc_up", {7'd0, up}, 8'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk($sformatf("sw_out[%0d]", i), {5'd0, out}, {5'd0, exp_sw12[i]});
            chk($sformatf("sw_up[%0d]", i), {7'd0, up}, {7'd0, exp_swup[i]});
            chk($sformatf("sw_wrap[%0d]", i), {7'd0, wrap}, 8'd0);
            chk($sformatf("sw_done[%0d]", i), {7'd0, done}, (i == 11) ? 8'd1 : 8'd0);
        end

        // ---- 5: UP 4 from 0 with two halted edges after step 1 ----
        halt = 1'b1;    // halt must not affect a LOAD in IDLE
        send(C_LOAD, 4'd0, 3'd0);
        chk("load0_halt_out", {5'd0, out}, 8'd0);
        halt = 1'b0;
        send(C_UP, 4'd4, 3'd0);          // edge k
        tick();                          // k+1: step 1
        chk("h_step1", {5'd0, out}, 8'd1);
        halt = 1'b1;
        tick();                          // k+2: halted
        chk("h_hold1", {5'd0, out}, 8'd1);
        chk("h_hold1_busy", {7'd0, busy}, 8'd1);
        tick();                          // k+3: halted
        chk("h_hold2", {5'd0, out}, 8'd1);
        halt = 1'b0;
        tick();                          // k+4
        chk("h_step2", {5'd0, out}, 8'd2);
        tick();                          // k+5
        chk("h_step3", {5'd0, out}, 8'd3);
        chk("h_nodone_k5", {7'd0, done}, 8'd0);
        tick();                          // k+6
        chk("h_step4", {5'd0, out}, 8'd4);
        chk("h_done_k6", {7'd0, done}, 8'd1);
        chk("h_busy_k6", {7'd0, busy}, 8'd0);
        tick();
        send(C_UP, 4'd0, 3'd0);
        chk("n0_done", {7'd0, done}, 8'd1);
        chk("n0_out", {5'd0, out}, 8'd4);
        chk("n0_busy", {7'd0, busy}, 8'd0);
        chk("n0_up", {7'd0, up}, 8'd1);

        // ---- 6: UP 6 aborted by reset after step 3; held command waits ----
        send(C_LOAD, 4'd0, 3'd0);
        send(C_UP, 4'd6, 3'd0);
        cmd_valid = 1'b1;                // held LOAD 7 while busy
        cmd_op    = C_LOAD;
        cmd_arg   = 4'd0;
        cmd_data  = 3'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("ab_out[%0d]", i), {5'd0, out}, 8'(i + 1));
            chk($sformatf("ab_ready[%0d]", i), {7'd0, cmd_ready}, 8'd0);
        end
        reset = 1'b1;
        tick();
        chk("ab_rst_out", {5'd0, out}, 8'd0);
        chk("ab_rst_busy", {7'd0, busy}, 8'd0);
        chk("ab_rst_up", {7'd0, up}, 8'd1);
        chk("ab_rst_done", {7'd0, done}, 8'd0);
        chk("ab_rst_ready", {7'd0, cmd_ready}, 8'd0);
        reset = 1'b0;
        tick();                          // held LOAD accepted now
        chk("ab_held_out", {5'd0, out}, 8'd7);
        chk("ab_held_done", {7'd0, done}, 8'd1);
        cmd_valid = 1'b0;
        tick();
        chk("ab_final_done", {7'd0, done}, 8'd0);
        chk("ab_final_out", {5'd0, out}, 8'd7);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_updown_count_sequencer
`default_nettype wire
